// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake.
//   Single-cycle ops (logic, add/sub/inc/dec, shifts) complete in one cycle.
//   Unsigned multiply iterates one multiplier bit per cycle, LSB first, for WIDTH cycles.
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start, op, a, b  request and operands, sampled only while busy=0
//   busy           high while the multiplier iterates
//   done           one-cycle pulse when result/flags are written
//   result         registered result
//   flag_z/c/n/v   zero, carry/borrow/shift-out, negative, overflow
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OpAnd = 4'b0001;
    localparam logic [3:0] OpXor = 4'b0010;
    localparam logic [3:0] OpOr  = 4'b0011;
    localparam logic [3:0] OpDec = 4'b0100;
    localparam logic [3:0] OpAdd = 4'b0101;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpInc = 4'b0111;
    localparam logic [3:0] OpShl = 4'b1000;
    localparam logic [3:0] OpShr = 4'b1001;
    localparam logic [3:0] OpMul = 4'b1010;

    typedef enum logic {StIdle, StMul} state_e;

    state_e               state_q, state_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;
    logic                 done_q, done_d;

    // Single-cycle datapath
    logic [SHW-1:0]       shamt;
    logic [WIDTH:0]       shl_ext;
    logic [WIDTH:0]       shr_ext;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_v;
    logic [2*WIDTH-1:0]   mul_sum;

    assign shamt   = b[SHW-1:0];
    // One guard bit catches the last bit shifted out; it is 0 for a zero amount.
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        alu_res = ~a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_ext = '0;
        case (op)
            OpAnd: alu_res = a & b;
            OpXor: alu_res = a ^ b;
            OpOr:  alu_res = a | b;
            OpDec: begin
                sum_ext = {1'b0, a} - {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = a[WIDTH-1] & ~alu_res[WIDTH-1];
            end
            OpAdd: begin
                sum_ext = {1'b0, a} + {1'b0, b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                sum_ext = {1'b0, a} - {1'b0, b};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) & (alu_res[WIDTH-1] != a[WIDTH-1]);
            end
            OpInc: begin
                sum_ext = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = ~a[WIDTH-1] & alu_res[WIDTH-1];
            end
            OpShl: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OpShr: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            default: alu_res = ~a;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        z_d      = z_q;
        c_d      = c_q;
        n_d      = n_q;
        v_d      = v_q;
        done_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (op == OpMul) begin
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        result_d = alu_res;
                        z_d      = (alu_res == '0);
                        c_d      = alu_c;
                        n_d      = alu_res[WIDTH-1];
                        v_d      = alu_v;
                        done_d   = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    result_d = mul_sum[WIDTH-1:0];
                    z_d      = (mul_sum[WIDTH-1:0] == '0);
                    c_d      = 1'b0;
                    n_d      = mul_sum[WIDTH-1];
                    v_d      = |mul_sum[2*WIDTH-1:WIDTH];
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            z_q      <= z_d;
            c_q      <= c_d;
            n_q      <= n_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q == StMul);
    assign done   = done_q;
    assign result = result_q;
    assign flag_z = z_q;
    assign flag_c = c_q;
    assign flag_n = n_q;
    assign flag_v = v_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU; successor to the combinational result-select stage of the datapath.
- Keeps the same 4-bit opcode map and generalises the operand width.
- Adds a start/busy/done handshake, an iterative shift-add multiplier, variable shifts and status flags.
- Sits between the register file operand latches and the controller FSM, which issues one op per start.

Parameters:
WIDTH, 16, operand/result width; power of two, >= 4.
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  4  opcode, sampled with start
a  input  WIDTH  operand A, sampled with start
b  input  WIDTH  operand B, sampled with start
busy  output  1  high while multiply iterates
done  output  1  one-cycle pulse when result/flags update
result  output  WIDTH  registered result
flag_z  output  1  result == 0
flag_c  output  1  carry/borrow/shifted-out bit
flag_n  output  1  result[WIDTH-1]
flag_v  output  1  signed overflow (add/sub/inc/dec) or multiply overflow

Behaviour:
- Reset, taken at any clk edge with rst=1 including mid-multiply: state=IDLE; busy, done, result and all flags = 0; iteration counter = 0. No done is issued for an aborted op.
- States:
  - IDLE: on start with op != 1010, compute the result, register result and flags, and pulse done the next cycle; stay in IDLE, so back-to-back ops run one per cycle. On start with op=1010, latch a and b, clear the accumulator and counter, go to MUL.
  - MUL: busy=1 for exactly WIDTH cycles; one multiplier bit is processed per cycle, LSB first. On the final iteration edge, write result and flags, pulse done, and return to IDLE with busy=0.
- Latency: start at cycle 0 gives done in cycle 1 for single-cycle ops and done in cycle WIDTH+1 for multiply.
- start is ignored while busy=1: no queuing, and operands are not re-sampled. start in the done cycle of a multiply is accepted, because the block is already in IDLE.
- result and flags hold between done pulses.
- Ops (arithmetic is modulo 2^WIDTH):
  - 0000 complement: ~a. c=0, v=0.
  - 0001 and: a&b. 0010 xor: a^b. 0011 or: a|b. For all three, c=0, v=0.
  - 0100 dec: a-1. c=1 iff a==0. v = signed overflow.
  - 0101 add: a+b. c = carry out. v = signed overflow.
  - 0110 sub: a-b. c=1 iff a<b unsigned (borrow). v = signed overflow.
  - 0111 inc: a+1. c=1 iff a is all ones. v = signed overflow.
  - 1000 shl: a << b[SHW-1:0]. c = last bit shifted out; c=0 when the amount is 0. v=0.
  - 1001 shr (logical): a >> b[SHW-1:0]. c as for shl. v=0.
  - 1010 mul (unsigned): result = low WIDTH bits of the 2*WIDTH-bit product. v=1 iff the high half != 0. c=0.
  - 1011-1111: treated as 0000.
- Bits of b above SHW are ignored for shifts.
- z and n are always derived from the written result.

Test Plan:
- WIDTH=16, add: a=7FFF, b=0001, start at cycle 0 -> cycle 1: done=1, result=8000, n=1, v=1, c=0, z=0.
- sub then inc back-to-back:
  - sub a=0000, b=0001 at cycle 0 -> cycle 1: result=FFFF, c=1, n=1.
  - inc a=FFFF at cycle 1 -> cycle 2: result=0000, z=1, c=1.
- mul a=0123, b=0010 -> busy high cycles 1-16; done at cycle 17 with result=1230, v=0. Then mul 0100*0100 -> result=0000, z=1, v=1.
- start op=0101 with a=1, b=1 at cycle 3 of a multiply -> ignored; only one done, carrying the multiply result. start in the done cycle is accepted, with done one cycle later.
- Shifts:
  - shl a=8001, b=0001 -> result=0002, c=1.
  - shr a=0003, b=0011 (amount 1) -> result=0001, c=1.
  - shl a=1234, b=0010 (amount 0) -> result=1234, c=0.
- rst asserted in cycle 5 of a multiply -> next cycle busy=0, result=0000, flags=0, no done. op=1111, a=00F0 -> result=FF0F.
